// File: rtl/debug_dump_scheduler_pkg.sv
// debug_dump_pkg: header magic and FSM state encodings shared by the debug dump scheduler files
package debug_dump_pkg;
    localparam logic [7:0] HDR_MAGIC = 8'hA5;
    localparam logic [2:0] W_IDLE  = 3'd0;
    localparam logic [2:0] W_HDR   = 3'd1;
    localparam logic [2:0] W_REGS  = 3'd2;
    localparam logic [2:0] W_MEM   = 3'd3;
    localparam logic [2:0] W_CSUM  = 3'd4;
    localparam logic [2:0] W_DRAIN = 3'd5;
    localparam logic [2:0] W_DONE  = 3'd6;
    localparam logic D_IDLE = 1'b0;
    localparam logic D_WAIT = 1'b1;
endpackage

// File: rtl/debug_dump_scheduler_if.sv
// debug_dump_scheduler_if: control, debug-read, TX FIFO and UART signals of the dump scheduler
interface debug_dump_scheduler_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MEM_ADDR_WIDTH = 8
);
    logic                      i_start;
    logic                      o_busy;
    logic                      o_done;
    logic [REG_ADDR_WIDTH-1:0] o_reg_addr;
    logic [31:0]               i_reg_data;
    logic [MEM_ADDR_WIDTH-1:0] o_mem_addr;
    logic [31:0]               i_mem_data;
    logic                      o_fifo_wr;
    logic [31:0]               o_fifo_wdata;
    logic                      i_fifo_full;
    logic                      i_fifo_empty;
    logic [7:0]                i_fifo_rd_data;
    logic                      o_fifo_rd;
    logic                      o_tx_start;
    logic [7:0]                o_tx_data;
    logic                      i_tx_done;
    modport master (
        input  i_start, i_reg_data, i_mem_data, i_fifo_full, i_fifo_empty, i_fifo_rd_data, i_tx_done,
        output o_busy, o_done, o_reg_addr, o_mem_addr, o_fifo_wr, o_fifo_wdata, o_fifo_rd, o_tx_start, o_tx_data
    );
    modport slave (
        output i_start, i_reg_data, i_mem_data, i_fifo_full, i_fifo_empty, i_fifo_rd_data, i_tx_done,
        input  o_busy, o_done, o_reg_addr, o_mem_addr, o_fifo_wr, o_fifo_wdata, o_fifo_rd, o_tx_start, o_tx_data
    );
endinterface

// File: rtl/debug_dump_scheduler_drainer.sv
// debug_byte_drainer: hands one FIFO byte to the UART per transmit completion, always running
module debug_byte_drainer
    import debug_dump_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_fifo_empty,
    input  logic [7:0] i_fifo_rd_data,
    input  logic       i_tx_done,
    output logic       o_fifo_rd,
    output logic       o_tx_start,
    output logic [7:0] o_tx_data,
    output logic       o_idle
);
    logic state_q, state_d;
    logic launch;
    always_comb begin
        o_idle     = state_q == D_IDLE;
        launch     = o_idle && !i_fifo_empty;
        o_fifo_rd  = launch;
        o_tx_start = launch;
        o_tx_data  = launch ? i_fifo_rd_data : 8'h00;
        state_d    = launch ? D_WAIT : (state_q == D_WAIT && i_tx_done) ? D_IDLE : state_q;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= D_IDLE;
        else         state_q <= state_d;
    end
endmodule

// File: rtl/debug_dump_scheduler.sv
// debug_dump_scheduler: streams header, register file and data memory words into the TX FIFO.
// Define DEBUG_DUMP_CHECKSUM_EN to append a running-XOR trailer word after the memory words.
module debug_dump_scheduler
    import debug_dump_pkg::*;
#(
    parameter int NUM_REGS       = 32,
    parameter int NUM_MEM_WORDS  = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MEM_ADDR_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    debug_dump_scheduler_if.master bus
);
`ifdef DEBUG_DUMP_CHECKSUM_EN
    localparam logic [2:0] AFTER_MEM = W_CSUM;
    logic [31:0] csum_q, csum_d;
`else
    localparam logic [2:0] AFTER_MEM = W_DRAIN;
`endif
    logic [2:0]  state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [31:0] wdata;
    logic        wr, wr_phase, last_reg, last_mem, drainer_idle;
    always_comb begin
        wr_phase = state_q inside {W_HDR, W_REGS, W_MEM}
`ifdef DEBUG_DUMP_CHECKSUM_EN
                   || state_q == W_CSUM
`endif
                   ;
        wr       = wr_phase && !bus.i_fifo_full;
        last_reg = idx_q == 8'(NUM_REGS - 1);
        last_mem = idx_q == 8'(NUM_MEM_WORDS - 1);
        wdata    = state_q == W_HDR  ? {HDR_MAGIC, 8'h00, 8'(NUM_REGS), 8'(NUM_MEM_WORDS)}
                 : state_q == W_REGS ? bus.i_reg_data
                 : state_q == W_MEM  ? bus.i_mem_data
`ifdef DEBUG_DUMP_CHECKSUM_EN
                 : state_q == W_CSUM ? csum_q
`endif
                 : 32'h0;
        bus.o_fifo_wr    = wr;
        bus.o_fifo_wdata = wdata;
        bus.o_busy       = state_q != W_IDLE && state_q != W_DONE;
        bus.o_done       = state_q == W_DONE;
        bus.o_reg_addr   = state_q == W_REGS ? REG_ADDR_WIDTH'(idx_q) : '0;
        bus.o_mem_addr   = state_q == W_MEM ? MEM_ADDR_WIDTH'(idx_q) : '0;
        state_d = state_q;
        idx_d   = idx_q;
        // the index only moves on an accepted write, so back-pressure holds the read address
        case (state_q)
            W_IDLE:  if (bus.i_start) begin state_d = W_HDR; idx_d = '0; end
            W_HDR:   if (wr) state_d = W_REGS;
            W_REGS:  if (wr) begin state_d = last_reg ? W_MEM : W_REGS; idx_d = last_reg ? 8'd0 : idx_q + 8'd1; end
            W_MEM:   if (wr) begin state_d = last_mem ? AFTER_MEM : W_MEM; idx_d = last_mem ? 8'd0 : idx_q + 8'd1; end
`ifdef DEBUG_DUMP_CHECKSUM_EN
            W_CSUM:  if (wr) state_d = W_DRAIN;
`endif
            W_DRAIN: if (bus.i_fifo_empty && drainer_idle) state_d = W_DONE;
            default: state_d = W_IDLE;
        endcase
`ifdef DEBUG_DUMP_CHECKSUM_EN
        csum_d = (state_q == W_IDLE && bus.i_start) ? 32'h0 : wr ? csum_q ^ wdata : csum_q;
`endif
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= W_IDLE;
            idx_q   <= '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
`ifdef DEBUG_DUMP_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end
    debug_byte_drainer u_drainer (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_fifo_empty   (bus.i_fifo_empty),
        .i_fifo_rd_data (bus.i_fifo_rd_data),
        .i_tx_done      (bus.i_tx_done),
        .o_fifo_rd      (bus.o_fifo_rd),
        .o_tx_start     (bus.o_tx_start),
        .o_tx_data      (bus.o_tx_data),
        .o_idle         (drainer_idle)
    );
endmodule
